// File: rtl/hs32_div_issuer.sv
`default_nettype none
// ============================================================================
// Module   : hs32_div_issuer
// Purpose  : Issues one divide request to the HS32 divider, waits for the
//            quotient/remainder steal announcements, captures the result bus
//            two cycles after each announcement and returns a response.
//            Requests that never complete are aborted after TIMEOUT cycles.
// Ports    : CCLK/SSE            clock, synchronous active-high reset
//            req_*               request handshake and operands
//            al_is_*, Dividend_*, Divisor   divider issue controls/operands
//            AttemptDivSteal2_6  quotient announcement
//            AttemptDivSteal1_6  remainder announcement
//            DivError_8, DivResBus_8        divider error and result bus
//            rsp_*               response handshake and captured results
//            spurious            sticky: unexpected steal observed
// Revision : 1.0 - initial release
// ============================================================================
module hs32_div_issuer #(
  parameter int TIMEOUT = 255
) (
  input  logic        CCLK,
  input  logic        SSE,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_dividend_hi,
  input  logic [63:0] req_dividend_lo,
  input  logic [63:0] req_divisor,
  input  logic        req_signed,
  input  logic        req_dual,
  input  logic        req_div8h,
  input  logic [3:0]  req_resen,
  output logic        al_is_DivIssue1_8,
  output logic        al_is_SignedMulDiv1_8,
  output logic        al_is_DualResMulDiv1_8,
  output logic        al_is_Div8Divh1_8,
  output logic [3:0]  al_is_ResEnable1_8,
  output logic [63:0] Dividend_hi,
  output logic [63:0] Dividend_lo,
  output logic [63:0] Divisor,
  input  logic        AttemptDivSteal2_6,
  input  logic        AttemptDivSteal1_6,
  input  logic        DivError_8,
  input  logic [63:0] DivResBus_8,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_quot,
  output logic [63:0] rsp_rem,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic        spurious
);

  localparam logic [8:0] c_timeout = 9'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
  logic        sgn_q, sgn_d, dual_q, dual_d, d8h_q, d8h_d;
  logic [3:0]  resen_q, resen_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [63:0] quot_q, quot_d, rem_q, rem_d;
  logic        err_q, err_d, tmo_q, tmo_d, spur_q, spur_d;
  logic        gotq_q, gotq_d, gotr_q, gotr_d;
  // Raw steal pipes see every announcement; the tracked pipes only carry
  // announcements made while a request is in flight (ISSUE/WAIT).
  logic [1:0]  qpipe_q, qpipe_d, rpipe_q, rpipe_d;
  logic [1:0]  qtrk_q, qtrk_d, rtrk_q, rtrk_d;

  logic w_track, w_in_wait, w_drive;
  logic w_cap_q, w_cap_r, w_spur_q, w_spur_r, w_rem_ignore, w_done, w_tmo;

  assign w_track   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign w_in_wait = (state_q == ST_WAIT);
  assign w_drive   = ~SSE & w_track;

  assign w_cap_q  = qpipe_q[1] & qtrk_q[1] & w_in_wait & ~gotq_q;
  assign w_cap_r  = rpipe_q[1] & rtrk_q[1] & w_in_wait & ~gotr_q & dual_q;
  // A remainder announcement during a single-result op carries no data we
  // keep; it is dropped rather than treated as unexpected.
  assign w_rem_ignore = rpipe_q[1] & rtrk_q[1] & w_in_wait & ~dual_q;
  assign w_spur_q = qpipe_q[1] & ~w_cap_q;
  assign w_spur_r = rpipe_q[1] & ~w_cap_r & ~w_rem_ignore;

  assign w_done = dual_q ? ((gotq_q | w_cap_q) & (gotr_q | w_cap_r) & (w_cap_q | w_cap_r))
                         : w_cap_q;
  // Fires in the cycle whose increment makes the counter reach TIMEOUT.
  assign w_tmo  = (cnt_q + 9'd1) >= c_timeout;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    sgn_d   = sgn_q;
    dual_d  = dual_q;
    d8h_d   = d8h_q;
    resen_d = resen_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    gotq_d  = gotq_q;
    gotr_d  = gotr_q;
    spur_d  = spur_q | w_spur_q | w_spur_r;
    qpipe_d = {qpipe_q[0], AttemptDivSteal2_6};
    rpipe_d = {rpipe_q[0], AttemptDivSteal1_6};
    qtrk_d  = {qtrk_q[0], AttemptDivSteal2_6 & w_track};
    rtrk_d  = {rtrk_q[0], AttemptDivSteal1_6 & w_track};

    if (w_cap_q) begin
      quot_d = DivResBus_8;
      gotq_d = 1'b1;
    end
    if (w_cap_r) begin
      rem_d  = DivResBus_8;
      gotr_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          hi_d    = req_dividend_hi;
          lo_d    = req_dividend_lo;
          dvs_d   = req_divisor;
          sgn_d   = req_signed;
          dual_d  = req_dual;
          d8h_d   = req_div8h;
          resen_d = req_resen;
          quot_d  = '0;
          rem_d   = '0;
          err_d   = 1'b0;
          tmo_d   = 1'b0;
          gotq_d  = 1'b0;
          gotr_d  = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        err_d   = err_q | DivError_8;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        err_d = err_q | DivError_8;
        cnt_d = (cnt_q >= c_timeout) ? cnt_q : cnt_q + 9'd1;
        // Completion is checked first so a capture coinciding with the
        // timeout cycle is reported as a normal result.
        if (w_done) begin
          tmo_d   = 1'b0;
          state_d = ST_RESP;
        end else if (w_tmo) begin
          tmo_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CCLK) begin
    if (SSE) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      sgn_q   <= 1'b0;
      dual_q  <= 1'b0;
      d8h_q   <= 1'b0;
      resen_q <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      gotq_q  <= 1'b0;
      gotr_q  <= 1'b0;
      spur_q  <= 1'b0;
      qpipe_q <= '0;
      rpipe_q <= '0;
      qtrk_q  <= '0;
      rtrk_q  <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      sgn_q   <= sgn_d;
      dual_q  <= dual_d;
      d8h_q   <= d8h_d;
      resen_q <= resen_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      gotq_q  <= gotq_d;
      gotr_q  <= gotr_d;
      spur_q  <= spur_d;
      qpipe_q <= qpipe_d;
      rpipe_q <= rpipe_d;
      qtrk_q  <= qtrk_d;
      rtrk_q  <= rtrk_d;
    end
  end

  // Outputs are forced low while SSE is held, before the state register
  // has had an edge to return to IDLE.
  assign req_ready              = ~SSE & (state_q == ST_IDLE);
  assign rsp_valid              = ~SSE & (state_q == ST_RESP);
  assign al_is_DivIssue1_8      = ~SSE & (state_q == ST_ISSUE);
  assign al_is_SignedMulDiv1_8  = w_drive & sgn_q;
  assign al_is_DualResMulDiv1_8 = w_drive & dual_q;
  assign al_is_Div8Divh1_8      = w_drive & d8h_q;
  assign al_is_ResEnable1_8     = w_drive ? resen_q : 4'd0;
  assign Dividend_hi            = w_drive ? hi_q  : 64'd0;
  assign Dividend_lo            = w_drive ? lo_q  : 64'd0;
  assign Divisor                = w_drive ? dvs_q : 64'd0;
  assign rsp_quot               = SSE ? 64'd0 : quot_q;
  assign rsp_rem                = SSE ? 64'd0 : rem_q;
  assign rsp_error              = ~SSE & err_q;
  assign rsp_timeout            = ~SSE & tmo_q;
  assign spurious               = ~SSE & spur_q;

endmodule
`default_nettype wire

// File: doc/hs32_div_issuer.md
HS32_DIV_ISSUER -- requirements
Module: hs32_div_issuer

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum cycles from issue to final result before the request is aborted.
REQ-002 CCLK  in  1  clock; all logic is on the rising edge.
REQ-003 SSE  in  1  synchronous active-high reset.
REQ-004 req_valid  in  1  request offered.
REQ-005 req_ready  out  1  issuer can accept a request.
REQ-006 req_dividend_hi, req_dividend_lo, req_divisor  in  64 each  operands.
REQ-007 req_signed, req_dual, req_div8h  in  1 each  signed op, dual-result op, div8/divh op.
REQ-008 req_resen  in  4  destination enables.
REQ-009 al_is_DivIssue1_8, al_is_SignedMulDiv1_8, al_is_DualResMulDiv1_8, al_is_Div8Divh1_8  out  1 each  divider issue controls.
REQ-010 al_is_ResEnable1_8  out  4  divider destination enables.
REQ-011 Dividend_hi, Dividend_lo, Divisor  out  64 each  divider operands.
REQ-012 AttemptDivSteal2_6, AttemptDivSteal1_6  in  1 each  quotient and remainder result announcements.
REQ-013 DivError_8  in  1  divide error (divide-by-zero or overflow).
REQ-014 DivResBus_8  in  64  divider result bus.
REQ-015 rsp_valid  out  1  response available.
REQ-016 rsp_ready  in  1  response consumed.
REQ-017 rsp_quot, rsp_rem  out  64 each  captured quotient and remainder.
REQ-018 rsp_error, rsp_timeout  out  1 each  divide error seen; timeout abort.
REQ-019 spurious  out  1  sticky flag: a steal was seen outside WAIT.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-021 req_ready SHALL be 1 only in IDLE.
REQ-022 A request SHALL be accepted when req_valid and req_ready are both 1, capturing all req_* fields into holding registers and moving to ISSUE.
REQ-023 In ISSUE, al_is_DivIssue1_8 SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-024 al_is_DivIssue1_8 SHALL be 0 in every other state.
REQ-025 The al_is_* control outputs and the operand outputs SHALL be driven from the holding registers from ISSUE until leaving WAIT, and held constant over that span.
REQ-026 In IDLE and RESP, the al_is_* control outputs and the operand outputs SHALL be 0.
REQ-027 A 9-bit wait counter SHALL clear on entry to WAIT and increment each cycle in WAIT, saturating at TIMEOUT.
REQ-028 A steal seen in cycle t (AttemptDivSteal2_6 for quotient, AttemptDivSteal1_6 for remainder) SHALL cause DivResBus_8 to be captured into rsp_quot or rsp_rem respectively at cycle t+2.
REQ-029 The 2-cycle steal delay SHALL be a two-stage shift pipe per steal, so back-to-back steals are both honoured.
REQ-030 Steals are tracked from the ISSUE cycle onward.
REQ-031 rsp_error SHALL be the OR of DivError_8 over all cycles from ISSUE until completion.
REQ-032 For req_dual=0, completion SHALL be the quotient capture.
REQ-033 For req_dual=1, completion SHALL be the later of the quotient and remainder captures, in either order.
REQ-034 On completion: WAIT -> RESP; rsp_valid=1; rsp_timeout=0.
REQ-035 If the counter reaches TIMEOUT before completion: WAIT -> RESP, rsp_timeout=1, and uncaptured result fields SHALL read 0.
REQ-036 rsp_valid SHALL be 1 only in RESP, and rsp_quot, rsp_rem, rsp_error and rsp_timeout SHALL be stable while it is 1.
REQ-037 RESP SHALL move to IDLE on rsp_ready=1.
REQ-038 A new request SHALL NOT be accepted in the cycle RESP exits.
REQ-039 rsp_rem SHALL read 0 for single-result ops.
REQ-040 A steal whose capture cycle falls in IDLE or RESP, or a second steal of the same kind within one request, SHALL set spurious and SHALL NOT alter captured data.
REQ-041 spurious SHALL clear only on SSE.
REQ-042 A capture and the timeout in the same cycle SHALL resolve as completion, not timeout.

Reset
REQ-043 While SSE=1: state = IDLE; req_ready = 0; all al_is_* outputs and operand outputs = 0; steal pipes, counter, rsp_* and spurious cleared.
REQ-044 SSE asserted mid-operation SHALL abandon the request with no response.
REQ-045 Divider results arriving after reset SHALL only set spurious.
REQ-046 req_ready SHALL be 1 in the first cycle after SSE falls.

Verification
REQ-047 Single-result op, divisor=7, dividend_lo=100; steal2 at t -> DivResBus_8=14 captured at t+2; rsp_quot=14, rsp_rem=0, rsp_error=0.
REQ-048 Dual-result op, hi=0, lo=100, divisor=7; steal2 and steal1 in consecutive cycles, bus values 14 then 2 -> rsp_quot=14, rsp_rem=2; al_is_DivIssue1_8 high exactly one cycle.
REQ-049 divisor=0 with DivError_8 pulsed once -> rsp_error=1 with whatever quotient was captured.
REQ-050 No steal, TIMEOUT=16 -> RESP entered 16 cycles after WAIT entry; rsp_timeout=1, rsp_quot=0.
REQ-051 SSE pulsed in WAIT, then steal2 -> no rsp_valid; spurious=1; req_ready=1.
REQ-052 rsp_ready held 0 for 5 cycles in RESP -> outputs stable; req_valid held 1 throughout -> accepted only after the RESP->IDLE cycle.
